// File: rtl/alu_pkg.sv
// Shared encodings for the operand loader and the 4-bit ALU datapath.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Phase codes double as the loader FSM state encoding, so the display stage reads the state directly.
package alu_pkg;

  localparam logic [2:0] PH_LOAD_A = 3'd0;
  localparam logic [2:0] PH_LOAD_B = 3'd1;
  localparam logic [2:0] PH_START  = 3'd2;
  localparam logic [2:0] PH_WAIT   = 3'd3;
  localparam logic [2:0] PH_SHOW   = 3'd4;

  typedef enum logic [2:0] {
    S_LOAD_A = PH_LOAD_A,
    S_LOAD_B = PH_LOAD_B,
    S_START  = PH_START,
    S_WAIT   = PH_WAIT,
    S_SHOW   = PH_SHOW
  } state_t;

  // Operation select codes driven on Select
  localparam logic [1:0] SEL_SUM = 2'b00;
  localparam logic [1:0] SEL_SUB = 2'b01;
  localparam logic [1:0] SEL_MUL = 2'b10;
  localparam logic [1:0] SEL_AND = 2'b11;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, optional debounce filter, rising-edge press pulse.
// Latency: press asserts 2 cycles after btn rises (plus DB_CYCLES filter delay with DEBOUNCE_EN).
// Backpressure: none; a held button produces exactly one press pulse.
// Build option: DEBOUNCE_EN enables the DB_CYCLES stability filter; otherwise the synchronised level is used.
// Ports: clk, rst (sync, active-high), btn (async raw button), press (1-cycle pulse).
module btn_debounce #(
  parameter int DB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  // DB_CYCLES of 0 would make the filter meaningless in either build
  if (DB_CYCLES < 1) begin : g_db_range
    $error("btn_debounce: DB_CYCLES must be >= 1");
  end

  logic sync_1;
  logic sync_2;
  logic level;
  logic level_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= btn;
      sync_2 <= sync_1;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [CW-1:0] db_cnt;
  logic          db_level;

  // Counts consecutive cycles where the synchronised input disagrees with
  // the accepted level; any agreeing cycle restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt   <= '0;
      db_level <= 1'b0;
    end else if (sync_2 == db_level) begin
      db_cnt <= '0;
    end else if (db_cnt == CNT_LAST) begin
      db_level <= sync_2;
      db_cnt   <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign level = db_level;
`else
  assign level = sync_2;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  assign press = level & ~level_q;

endmodule

// File: rtl/operand_loader.sv
// Sequencer: loads A then B from one switch bank by button presses, starts the ALU, captures its result.
// Latency: Start is high the cycle after the B press is seen; result captured on the first Alu_done cycle.
// Backpressure: presses arriving in S_START/S_WAIT are dropped; Alu_done outside S_WAIT is ignored.
// Build option: DEBOUNCE_EN (passed to btn_debounce) enables the button stability filter.
// Ports: Clk, Rst (sync, active-high); Sw, Sel_sw, Btn (async user inputs);
//        Alu_done/Alu_sal/Alu_cout from the ALU; A/B/Select/Start to the ALU;
//        Busy, Result, Result_cout, Result_valid, Timeout, Phase to the display stage.
module operand_loader
  import alu_pkg::*;
#(
  parameter int W         = 4,
  parameter int DB_CYCLES = 250000,
  parameter int TIMEOUT   = 64
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic [W-1:0]   Sw,
  input  logic [1:0]     Sel_sw,
  input  logic           Btn,
  input  logic           Alu_done,
  input  logic [2*W-1:0] Alu_sal,
  input  logic           Alu_cout,
  output logic [W-1:0]   A,
  output logic [W-1:0]   B,
  output logic [1:0]     Select,
  output logic           Start,
  output logic           Busy,
  output logic [2*W-1:0] Result,
  output logic           Result_cout,
  output logic           Result_valid,
  output logic           Timeout,
  output logic [2:0]     Phase
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  state_t        state;
  state_t        state_n;
  logic          press;
  logic [TW-1:0] wait_cnt;
  logic          wait_expired;

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_btn (
    .clk   (Clk),
    .rst   (Rst),
    .btn   (Btn),
    .press (press)
  );

  assign wait_expired = (wait_cnt == T_LAST);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= S_LOAD_A;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_LOAD_A: if (press) state_n = S_LOAD_B;
      S_LOAD_B: if (press) state_n = S_START;
      S_START:  state_n = S_WAIT;
      S_WAIT:   if (Alu_done || wait_expired) state_n = S_SHOW;
      S_SHOW:   if (press) state_n = S_LOAD_A;
      default:  state_n = S_LOAD_A;
    endcase
  end

  // Start/Busy are registered from the next state so they line up exactly
  // with the cycles the FSM spends in S_START / S_WAIT.
  // Switches are assumed static while the button is pressed, so they are
  // latched without their own synchroniser.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      A            <= '0;
      B            <= '0;
      Select       <= '0;
      Start        <= 1'b0;
      Busy         <= 1'b0;
      Result       <= '0;
      Result_cout  <= 1'b0;
      Result_valid <= 1'b0;
      Timeout      <= 1'b0;
      wait_cnt     <= '0;
    end else begin
      Start <= (state_n == S_START);
      Busy  <= (state_n == S_START) || (state_n == S_WAIT);

      if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end

      if (state == S_LOAD_A && press) begin
        A <= Sw;
      end

      if (state == S_LOAD_B && press) begin
        B      <= Sw;
        Select <= Sel_sw;
      end

      // Done is checked first so it wins over a same-cycle timeout
      if (state == S_WAIT) begin
        if (Alu_done) begin
          Result       <= Alu_sal;
          Result_cout  <= Alu_cout;
          Result_valid <= 1'b1;
        end else if (wait_expired) begin
          Timeout <= 1'b1;
        end
      end

      // Result/Result_cout keep their last values for the display stage
      if (state == S_SHOW && press) begin
        Result_valid <= 1'b0;
        Timeout      <= 1'b0;
      end
    end
  end

  assign Phase = state;

endmodule

// File: tb/tb_operand_loader.sv
module tb_operand_loader;
  import alu_pkg::*;

  localparam int W = 4;

  logic           Clk = 1'b0;
  logic           Rst = 1'b1;
  logic [W-1:0]   Sw = '0;
  logic [1:0]     Sel_sw = '0;
  logic           Btn = 1'b0;
  logic           Alu_done;
  logic [2*W-1:0] Alu_sal;
  logic           Alu_cout;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic [1:0]     Select;
  logic           Start;
  logic           Busy;
  logic [2*W-1:0] Result;
  logic           Result_cout;
  logic           Result_valid;
  logic           Timeout;
  logic [2:0]     Phase;

  logic           model_done = 1'b0;
  logic           force_done = 1'b0;
  logic [7:0]     model_sal = '0;
  logic           model_cout = 1'b0;
  logic           alu_en = 1'b1;
  logic [3:0]     cur_a = '0;
  logic [3:0]     cur_b = '0;
  logic [1:0]     cur_sel = '0;

  int total = 0;
  int bad = 0;
  int start_cycles = 0;
  int wait_cycles = 0;

  assign Alu_done = model_done | force_done;
  assign Alu_sal  = model_sal;
  assign Alu_cout = model_cout;

  operand_loader #(
    .W         (W),
    .DB_CYCLES (4),
    .TIMEOUT   (16)
  ) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .Sw           (Sw),
    .Sel_sw       (Sel_sw),
    .Btn          (Btn),
    .Alu_done     (Alu_done),
    .Alu_sal      (Alu_sal),
    .Alu_cout     (Alu_cout),
    .A            (A),
    .B            (B),
    .Select       (Select),
    .Start        (Start),
    .Busy         (Busy),
    .Result       (Result),
    .Result_cout  (Result_cout),
    .Result_valid (Result_valid),
    .Timeout      (Timeout),
    .Phase        (Phase)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (Start === 1'b1) start_cycles++;
    if (Phase === 3'd3) wait_cycles++;
  end

  function automatic logic [8:0] alu_calc(input logic [3:0] a, input logic [3:0] b, input logic [1:0] sel);
    logic [7:0] r;
    logic       c;
    r = '0;
    c = 1'b0;
    case (sel)
      SEL_SUM: begin r = {4'd0, a} + {4'd0, b}; c = r[4]; end
      SEL_SUB: begin r = {4'd0, a} - {4'd0, b}; c = (a < b); end
      SEL_MUL: r = a * b;
      default: r = {4'd0, a & b};
    endcase
    return {c, r};
  endfunction

  // ALU model: Done rises 3 cycles after Start is seen, held for 2 cycles
  always @(negedge Clk) begin
    if (Start === 1'b1 && alu_en) begin
      repeat (3) @(posedge Clk);
      #1;
      {model_cout, model_sal} = alu_calc(cur_a, cur_b, cur_sel);
      model_done = 1'b1;
      repeat (2) @(posedge Clk);
      #1 model_done = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_press(input logic [3:0] sw, input logic [1:0] sel);
    Sw = sw;
    Sel_sw = sel;
    Btn = 1'b1;
    repeat (8) @(posedge Clk);
    #1 Btn = 1'b0;
    repeat (8) @(posedge Clk);
    #1;
  endtask

  task automatic wait_phase(input logic [2:0] ph, input int budget, input string tag);
    int n;
    n = 0;
    while (Phase !== ph && n < budget) begin
      @(posedge Clk);
      #1;
      n++;
    end
    chk(tag, {13'd0, Phase}, {13'd0, ph});
  endtask

  initial begin
    // 1. reset
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_a", {12'd0, A}, 16'h0);
    chk("rst_b", {12'd0, B}, 16'h0);
    chk("rst_sel", {14'd0, Select}, 16'h0);
    chk("rst_start", {15'd0, Start}, 16'h0);
    chk("rst_busy", {15'd0, Busy}, 16'h0);
    chk("rst_result", {8'd0, Result}, 16'h0);
    chk("rst_valid", {15'd0, Result_valid}, 16'h0);
    chk("rst_timeout", {15'd0, Timeout}, 16'h0);
    chk("rst_phase", {13'd0, Phase}, 16'h0);
    Rst = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    chk("idle_no_start", start_cycles[15:0], 16'd0);

    // 2. 3 + 5 with SUM
    cur_a = 4'd3;
    do_press(4'd3, 2'b00);
    chk("load_a", {12'd0, A}, 16'h3);
    chk("phase_b", {13'd0, Phase}, 16'd1);
    cur_b = 4'd5;
    cur_sel = SEL_SUM;
    do_press(4'd5, SEL_SUM);
    wait_phase(3'd4, 50, "show_sum");
    chk("load_b", {12'd0, B}, 16'h5);
    chk("select_sum", {14'd0, Select}, 16'h0);
    chk("result_sum", {8'd0, Result}, 16'h08);
    chk("cout_sum", {15'd0, Result_cout}, 16'h0);
    chk("valid_sum", {15'd0, Result_valid}, 16'h1);
    chk("start_once", start_cycles[15:0], 16'd1);
    chk("busy_show", {15'd0, Busy}, 16'h0);

    // 3. held button across SHOW -> LOAD_A consumes one press only
    Sw = 4'd9;
    Btn = 1'b1;
    repeat (20) @(posedge Clk);
    #1;
    chk("hold_phase", {13'd0, Phase}, 16'd0);
    chk("hold_a", {12'd0, A}, 16'h3);
    chk("hold_valid", {15'd0, Result_valid}, 16'h0);
    chk("hold_result", {8'd0, Result}, 16'h08);
    Btn = 1'b0;
    repeat (8) @(posedge Clk);
    #1;
    chk("release_phase", {13'd0, Phase}, 16'd0);
    cur_a = 4'd9;
    do_press(4'd9, 2'b00);
    chk("load_a2", {12'd0, A}, 16'h9);
    cur_b = 4'd6;
    cur_sel = SEL_MUL;
    do_press(4'd6, SEL_MUL);
    wait_phase(3'd4, 50, "show_mul");
    chk("select_mul", {14'd0, Select}, 16'h2);
    chk("result_mul", {8'd0, Result}, 16'h36);
    chk("valid_mul", {15'd0, Result_valid}, 16'h1);
    do_press(4'd0, 2'b00);
    chk("ack_phase", {13'd0, Phase}, 16'd0);
    chk("ack_valid", {15'd0, Result_valid}, 16'h0);
    chk("ack_result_hold", {8'd0, Result}, 16'h36);

    // 4. short pulses
    Sw = 4'd4;
`ifdef DEBOUNCE_EN
    for (int g = 0; g < 3; g++) begin
      Btn = 1'b1;
      repeat (2) @(posedge Clk);
      #1 Btn = 1'b0;
      repeat (6) @(posedge Clk);
      #1;
    end
    chk("glitch_phase", {13'd0, Phase}, 16'd0);
    chk("glitch_a", {12'd0, A}, 16'h9);
    Btn = 1'b1;
    repeat (6) @(posedge Clk);
    #1 Btn = 1'b0;
    repeat (10) @(posedge Clk);
    #1;
`else
    Btn = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Btn = 1'b0;
    repeat (6) @(posedge Clk);
    #1;
`endif
    cur_a = 4'd4;
    chk("pulse_phase", {13'd0, Phase}, 16'd1);
    chk("pulse_a", {12'd0, A}, 16'h4);

    // 5. timeout with no Done
    alu_en = 1'b0;
    wait_cycles = 0;
    cur_b = 4'd2;
    cur_sel = SEL_AND;
    do_press(4'd2, SEL_AND);
    wait_phase(3'd4, 60, "show_timeout");
    chk("timeout_set", {15'd0, Timeout}, 16'h1);
    chk("timeout_valid", {15'd0, Result_valid}, 16'h0);
    chk("timeout_wait_len", wait_cycles[15:0], 16'd16);
    chk("timeout_result_hold", {8'd0, Result}, 16'h36);
    do_press(4'd0, 2'b00);
    chk("timeout_clear", {15'd0, Timeout}, 16'h0);
    chk("timeout_ack_phase", {13'd0, Phase}, 16'd0);

    // 6. reset during WAIT, then a late Done
    do_press(4'd1, 2'b00);
    do_press(4'd1, SEL_SUM);
    chk("mid_wait_phase", {13'd0, Phase}, 16'd3);
    chk("mid_wait_busy", {15'd0, Busy}, 16'h1);
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    force_done = 1'b1;
    Rst = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("late_done_phase", {13'd0, Phase}, 16'd0);
    chk("late_done_valid", {15'd0, Result_valid}, 16'h0);
    chk("late_done_result", {8'd0, Result}, 16'h0);
    chk("late_done_a", {12'd0, A}, 16'h0);
    chk("late_done_busy", {15'd0, Busy}, 16'h0);
    force_done = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
